speed_meter_bcd: RTL

//  Parametrised pulse-rate meter: filters and edge-detects a speed pulse input and counts

---
 rtl/speed_meter_bcd_if.sv | 32 +++
 rtl/speed_meter_bcd.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/speed_meter_bcd_if.sv
`default_nettype none
// ============================================================================
//  Module   : speed_meter_bcd_if
//  Brief    : Pulse input and BCD result bundle of the speed meter.
//  Revision : 1.0 - initial release
// ============================================================================
interface speed_meter_bcd_if #(
   parameter int DIGITS = 6
);
   logic                  speed_in;
   logic [4*DIGITS-1:0]   bcd_out;
   logic                  bcd_valid;
   logic                  overflow;
   logic                  win_tick;

   modport master (
      output speed_in,
      input  bcd_out,
      input  bcd_valid,
      input  overflow,
      input  win_tick
   );

   modport slave (
      input  speed_in,
      output bcd_out,
      output bcd_valid,
      output overflow,
      output win_tick
   );
endinterface
`default_nettype wire

// File: rtl/speed_meter_bcd.sv
`default_nettype none
// ============================================================================
//  Module   : speed_meter_bcd
//  Brief    : Filtered pulse-rate meter with sequential binary-to-BCD output.
//             Define SPEED_METER_LZB_EN for leading-zero blanking (4'hF digits).
//  Revision : 1.0 - initial release
// ============================================================================
module speed_meter_bcd #(
   parameter int WINDOW_CYC = 50_000_000,
   parameter int CNT_W      = 24,
   parameter int DIGITS     = 6,
   parameter int FILT_LEN   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   speed_meter_bcd_if.slave  bus
);

   localparam int c_tmr_w  = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
   localparam int c_filt_w = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
   localparam int c_bit_w  = (CNT_W > 1) ? $clog2(CNT_W) : 1;
   localparam int c_bcd_w  = 4*DIGITS + 4;

   localparam logic [c_tmr_w-1:0]  c_tmr_last  = c_tmr_w'(WINDOW_CYC - 1);
   localparam logic [c_filt_w-1:0] c_filt_last = c_filt_w'(FILT_LEN - 1);
   localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(CNT_W - 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   function automatic logic [63:0] f_max_val(input int n);
      logic [63:0] v;
      v = 64'd1;
      for (int i = 0; i < n; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

   localparam logic [63:0] c_max_val = f_max_val(DIGITS);

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   logic [1:0]          r_sync;
   logic [c_filt_w-1:0] r_filt_cnt;
   logic                r_filt_level;
   logic                r_filt_prev;
   logic                w_edge;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[0], bus.speed_in};
      end
   end

   // Level flips only once the synced input has disagreed for FILT_LEN cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_filt_cnt   <= '0;
         r_filt_level <= 1'b0;
         r_filt_prev  <= 1'b0;
      end else begin
         r_filt_prev <= r_filt_level;
         if (r_sync[1] == r_filt_level) begin
            r_filt_cnt <= '0;
         end else if (r_filt_cnt == c_filt_last) begin
            r_filt_level <= r_sync[1];
            r_filt_cnt   <= '0;
         end else begin
            r_filt_cnt <= r_filt_cnt + 1'b1;
         end
      end
   end

   assign w_edge = r_filt_level & ~r_filt_prev;

   // ------------------------------------------------------------------
   // Gate window and edge counter
   // ------------------------------------------------------------------
   logic [c_tmr_w-1:0] r_timer;
   logic               w_win_tick;
   logic [CNT_W-1:0]   r_count;
   logic               r_sat;
   logic               w_cnt_max;
   logic [CNT_W-1:0]   w_cnt_next;
   logic               w_sat_next;

   assign w_win_tick = (r_timer == c_tmr_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_timer <= '0;
      end else if (w_win_tick) begin
         r_timer <= '0;
      end else begin
         r_timer <= r_timer + 1'b1;
      end
   end

   // Next-count values include an edge landing on the closing cycle.
   assign w_cnt_max  = (r_count == {CNT_W{1'b1}});
   assign w_cnt_next = (w_edge && !w_cnt_max) ? r_count + 1'b1 : r_count;
   assign w_sat_next = r_sat | (w_edge & w_cnt_max);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else if (w_win_tick) begin
         r_count <= '0;
         r_sat   <= 1'b0;
      end else begin
         r_count <= w_cnt_next;
         r_sat   <= w_sat_next;
      end
   end

   // ------------------------------------------------------------------
   // Double-dabble conversion
   // ------------------------------------------------------------------
   logic [1:0]          r_state;
   logic [CNT_W-1:0]    r_snapshot;
   logic                r_snap_sat;
   logic [CNT_W-1:0]    r_bin;
   logic [c_bcd_w-1:0]  r_bcd;
   logic [c_bit_w-1:0]  r_bit_cnt;
   logic [c_bcd_w-1:0]  w_bcd_adj;

   for (genvar gi = 0; gi < DIGITS + 1; gi++) begin : g_dabble
      logic [3:0] w_dig;
      assign w_dig = r_bcd[4*gi +: 4];
      assign w_bcd_adj[4*gi +: 4] = (w_dig >= 4'd5) ? w_dig + 4'd3 : w_dig;
   end

   // ------------------------------------------------------------------
   // Range check and output formatting
   // ------------------------------------------------------------------
   logic [63:0]           w_snap_ext;
   logic                  w_ovf;
   logic [4*DIGITS-1:0]   w_conv;
   logic [4*DIGITS-1:0]   w_blanked;
   logic [4*DIGITS-1:0]   w_result;

   assign w_snap_ext = {{(64-CNT_W){1'b0}}, r_snapshot};
   assign w_conv     = r_bcd[4*DIGITS-1:0];
   assign w_ovf      = r_snap_sat
                     || (w_snap_ext > c_max_val)
                     || (r_bcd[c_bcd_w-1 -: 4] != 4'd0);

`ifdef SPEED_METER_LZB_EN
   always_comb begin
      logic w_lead;
      w_blanked = w_conv;
      w_lead    = 1'b1;
      // Digit 0 is never blanked so a zero reading still shows "0".
      for (int i = DIGITS - 1; i >= 1; i--) begin
         if (w_lead && (w_conv[4*i +: 4] == 4'd0)) begin
            w_blanked[4*i +: 4] = 4'hF;
         end else begin
            w_lead = 1'b0;
         end
      end
   end
`else
   assign w_blanked = w_conv;
`endif

   assign w_result = w_ovf ? {DIGITS{4'h9}} : w_blanked;

   // ------------------------------------------------------------------
   // Control FSM and output registers
   // ------------------------------------------------------------------
   logic [4*DIGITS-1:0] r_bcd_out;
   logic                r_bcd_valid;
   logic                r_overflow;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_snapshot  <= '0;
         r_snap_sat  <= 1'b0;
         r_bin       <= '0;
         r_bcd       <= '0;
         r_bit_cnt   <= '0;
         r_bcd_out   <= '0;
         r_bcd_valid <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_bcd_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_win_tick) begin
                  r_snapshot <= w_cnt_next;
                  r_snap_sat <= w_sat_next;
                  r_bin      <= w_cnt_next;
                  r_bcd      <= '0;
                  r_bit_cnt  <= '0;
                  r_state    <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               r_bcd <= c_bcd_w'({w_bcd_adj, r_bin[CNT_W-1]});
               r_bin <= r_bin << 1;
               if (r_bit_cnt == c_bit_last) begin
                  r_state <= S_DONE;
               end else begin
                  r_bit_cnt <= r_bit_cnt + 1'b1;
               end
            end
            S_DONE: begin
               r_bcd_out   <= w_result;
               r_overflow  <= w_ovf;
               r_bcd_valid <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.bcd_out   = r_bcd_out;
   assign bus.bcd_valid = r_bcd_valid;
   assign bus.overflow  = r_overflow;
   assign bus.win_tick  = w_win_tick;

   // A window closing mid-conversion means WINDOW_CYC is too short for CNT_W.
   a_win_tick_idle: assert property (@(posedge clk) disable iff (!rst_n)
                                     w_win_tick |-> (r_state == S_IDLE));

endmodule
`default_nettype wire
